// File: rtl/spi_minion_core.sv
// SPI mode-0 minion core: synchronizes the SPI pins into clk, shifts packets
// in and out, and exchanges them through pull/push ports. SPI_MINION_CORE_ABORT_CNT_EN adds abort_cnt.
module spi_minion_core #(
    parameter int nbits = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             spi_cs,
    input  logic             spi_sclk,
    input  logic             spi_mosi,
    output logic             spi_miso,
    output logic             pull_en,
    input  logic             pull_msg_val,
    input  logic             pull_msg_spc,
    input  logic [nbits-3:0] pull_msg_data,
    output logic             push_en,
    output logic             push_msg_val_wrt,
    output logic             push_msg_val_rd,
    output logic [nbits-3:0] push_msg_data
`ifdef SPI_MINION_CORE_ABORT_CNT_EN
    ,
    output logic [7:0]       abort_cnt
`endif
);

    localparam int CW = $clog2(nbits + 2);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

    state_t           r_state;
    logic             r_cs_s1, r_cs_s2, r_cs_h;
    logic             r_sclk_s1, r_sclk_s2, r_sclk_h;
    logic             r_mosi_s1, r_mosi_s2, r_mosi_h;
    logic [nbits-1:0] r_rx;
    logic [nbits-1:0] r_tx;
    logic [CW-1:0]    r_bit_cnt;
    logic [1:0]       r_flush;
    logic             r_cs_hi_seen;
    logic             r_pull_en;
    logic             r_push_en;
    logic             r_push_wrt;
    logic             r_push_rd;
    logic [nbits-3:0] r_push_data;
`ifdef SPI_MINION_CORE_ABORT_CNT_EN
    logic [7:0]       r_abort;
`endif

    logic w_cs_rise;
    logic w_sclk_rise;
    logic w_sclk_fall;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cs_s1   <= 1'b1;
            r_cs_s2   <= 1'b1;
            r_cs_h    <= 1'b1;
            r_sclk_s1 <= 1'b0;
            r_sclk_s2 <= 1'b0;
            r_sclk_h  <= 1'b0;
            r_mosi_s1 <= 1'b0;
            r_mosi_s2 <= 1'b0;
            r_mosi_h  <= 1'b0;
        end else begin
            r_cs_s1   <= spi_cs;
            r_cs_s2   <= r_cs_s1;
            r_cs_h    <= r_cs_s2;
            r_sclk_s1 <= spi_sclk;
            r_sclk_s2 <= r_sclk_s1;
            r_sclk_h  <= r_sclk_s2;
            r_mosi_s1 <= spi_mosi;
            r_mosi_s2 <= r_mosi_s1;
            r_mosi_h  <= r_mosi_s2;
        end
    end

    assign w_cs_rise   =  r_cs_s2   & ~r_cs_h;
    assign w_sclk_rise =  r_sclk_s2 & ~r_sclk_h;
    assign w_sclk_fall = ~r_sclk_s2 &  r_sclk_h;

    // A packet starts only once cs has been seen high after the reset-value
    // synchronizer contents are flushed; this level history also keeps a cs
    // fall that lands in DONE from being lost.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_rx         <= '0;
            r_tx         <= '0;
            r_bit_cnt    <= '0;
            r_flush      <= '0;
            r_cs_hi_seen <= 1'b0;
            r_pull_en    <= 1'b0;
            r_push_en    <= 1'b0;
            r_push_wrt   <= 1'b0;
            r_push_rd    <= 1'b0;
            r_push_data  <= '0;
`ifdef SPI_MINION_CORE_ABORT_CNT_EN
            r_abort      <= '0;
`endif
        end else begin
            r_pull_en <= 1'b0;
            r_push_en <= 1'b0;
            if (r_flush != 2'd2) begin
                r_flush <= r_flush + 2'd1;
            end else if (r_cs_s2) begin
                r_cs_hi_seen <= 1'b1;
            end

            case (r_state)
                IDLE: begin
                    if (r_cs_hi_seen && !r_cs_s2) begin
                        r_state      <= LOAD;
                        r_pull_en    <= 1'b1;
                        r_bit_cnt    <= '0;
                        r_cs_hi_seen <= 1'b0;
                    end
                end
                LOAD: begin
                    r_tx    <= {pull_msg_val, pull_msg_spc, pull_msg_data};
                    r_state <= SHIFT;
                end
                SHIFT: begin
                    if (w_sclk_rise) begin
                        r_rx <= {r_rx[nbits-2:0], r_mosi_h};
                        if (r_bit_cnt != CW'(nbits + 1)) begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end
                    if (w_sclk_fall) begin
                        r_tx <= {r_tx[nbits-2:0], 1'b0};
                    end
                    if (w_cs_rise) begin
                        r_state <= DONE;
                        if (r_bit_cnt == CW'(nbits)) begin
                            r_push_en   <= 1'b1;
                            r_push_wrt  <= r_rx[nbits-1];
                            r_push_rd   <= r_rx[nbits-2];
                            r_push_data <= r_rx[nbits-3:0];
                        end
`ifdef SPI_MINION_CORE_ABORT_CNT_EN
                        else if (r_abort != 8'hFF) begin
                            r_abort <= r_abort + 8'd1;
                        end
`endif
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign spi_miso         = ~r_cs_s2 & r_tx[nbits-1];
    assign pull_en          = r_pull_en;
    assign push_en          = r_push_en;
    assign push_msg_val_wrt = r_push_wrt;
    assign push_msg_val_rd  = r_push_rd;
    assign push_msg_data    = r_push_data;
`ifdef SPI_MINION_CORE_ABORT_CNT_EN
    assign abort_cnt        = r_abort;
`endif

endmodule

// File: tb/tb_spi_minion_core.sv
// Scoreboard bench for spi_minion_core (nbits = 8): expected pushes are queued
// as packets are sent and checked by a monitor when push_en fires.
module tb_spi_minion_core;

    localparam int NB = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          spi_cs;
    logic          spi_sclk;
    logic          spi_mosi;
    logic          spi_miso;
    logic          pull_en;
    logic          pull_msg_val;
    logic          pull_msg_spc;
    logic [NB-3:0] pull_msg_data;
    logic          push_en;
    logic          push_msg_val_wrt;
    logic          push_msg_val_rd;
    logic [NB-3:0] push_msg_data;
`ifdef SPI_MINION_CORE_ABORT_CNT_EN
    logic [7:0]    abort_cnt;
`endif

    spi_minion_core #(.nbits(NB)) dut (
        .clk              (clk),
        .reset            (reset),
        .spi_cs           (spi_cs),
        .spi_sclk         (spi_sclk),
        .spi_mosi         (spi_mosi),
        .spi_miso         (spi_miso),
        .pull_en          (pull_en),
        .pull_msg_val     (pull_msg_val),
        .pull_msg_spc     (pull_msg_spc),
        .pull_msg_data    (pull_msg_data),
        .push_en          (push_en),
        .push_msg_val_wrt (push_msg_val_wrt),
        .push_msg_val_rd  (push_msg_val_rd),
        .push_msg_data    (push_msg_data)
`ifdef SPI_MINION_CORE_ABORT_CNT_EN
        ,
        .abort_cnt        (abort_cnt)
`endif
    );

    always #5 clk = ~clk;

    int         total = 0;
    int         bad   = 0;
    int         pull_cnt = 0;
    logic [7:0] exp_q[$];
    logic [7:0] mon_exp;

    always @(negedge clk) begin
        if (pull_en === 1'b1) pull_cnt++;
        if (push_en === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL push_unexpected got=%h required=no push",
                         {push_msg_val_wrt, push_msg_val_rd, push_msg_data});
            end else begin
                mon_exp = exp_q.pop_front();
                if ({push_msg_val_wrt, push_msg_val_rd, push_msg_data} !== mon_exp) begin
                    bad++;
                    $display("FAIL push_data got=%h required=%h",
                             {push_msg_val_wrt, push_msg_val_rd, push_msg_data}, mon_exp);
                end
            end
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic spi_xfer(input logic [7:0] mo, input int pulses, output logic [7:0] mi);
        mi = '0;
        spi_cs = 1'b0;
        #100;
        for (int i = 0; i < pulses; i++) begin
            spi_mosi = (i < 8) ? mo[7-i] : 1'b0;
            #50 spi_sclk = 1'b1;
            if (i < 8) mi[7-i] = spi_miso;
            #50 spi_sclk = 1'b0;
        end
        #50;
        spi_cs   = 1'b1;
        spi_mosi = 1'b0;
    endtask

    task automatic check_drained(input string name);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL %s pending_pushes got=%0d required=0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic check_pulls(input string name, input int got, input int req);
        total++;
        if (got !== req) begin
            bad++;
            $display("FAIL %s pull_en_cycles got=%0d required=%0d", name, got, req);
        end
    endtask

    task automatic test_reset;
        int p0;
        reset = 1'b1; spi_cs = 1'b1; spi_sclk = 1'b0; spi_mosi = 1'b0;
        pull_msg_val = 1'b0; pull_msg_spc = 1'b0; pull_msg_data = '0;
        wait_clk(3);
        total++;
        if ({spi_miso, pull_en, push_en} !== 3'b000) begin
            bad++;
            $display("FAIL reset_strobes got=%b required=000", {spi_miso, pull_en, push_en});
        end
        total++;
        if ({push_msg_val_wrt, push_msg_val_rd, push_msg_data} !== 8'h00) begin
            bad++;
            $display("FAIL reset_push_msg got=%h required=00",
                     {push_msg_val_wrt, push_msg_val_rd, push_msg_data});
        end
`ifdef SPI_MINION_CORE_ABORT_CNT_EN
        total++;
        if (abort_cnt !== 8'd0) begin
            bad++;
            $display("FAIL reset_abort_cnt got=%0d required=0", abort_cnt);
        end
`endif
        p0 = pull_cnt;
        reset = 1'b0;
        wait_clk(10);
        check_pulls("reset_idle", pull_cnt - p0, 0);
    endtask

    task automatic test_write;
        int p0;
        logic [7:0] mi;
        pull_msg_val = 1'b0; pull_msg_spc = 1'b1; pull_msg_data = 6'h00;
        p0 = pull_cnt;
        exp_q.push_back({1'b1, 1'b0, 6'h2A});
        spi_xfer(8'b10_101010, 8, mi);
        wait_clk(10);
        check_drained("write");
        check_pulls("write", pull_cnt - p0, 1);
        total++;
        if (mi !== 8'h40) begin
            bad++;
            $display("FAIL write_miso got=%h required=40", mi);
        end
    endtask

    task automatic test_read;
        logic [7:0] mi;
        pull_msg_val = 1'b1; pull_msg_spc = 1'b1; pull_msg_data = 6'h15;
        exp_q.push_back({1'b0, 1'b1, 6'h00});
        spi_xfer(8'b01_000000, 8, mi);
        wait_clk(10);
        check_drained("read");
        total++;
        if (mi !== 8'b1101_0101) begin
            bad++;
            $display("FAIL read_miso got=%b required=11010101", mi);
        end
    endtask

    task automatic test_short;
        int p0;
        logic [7:0] mi;
`ifdef SPI_MINION_CORE_ABORT_CNT_EN
        logic [7:0] a0;
        a0 = abort_cnt;
`endif
        p0 = pull_cnt;
        spi_xfer(8'hFF, 5, mi);
        wait_clk(10);
        check_pulls("short", pull_cnt - p0, 1);
        total++;
        if ({push_msg_val_wrt, push_msg_val_rd, push_msg_data} !== 8'h40) begin
            bad++;
            $display("FAIL short_hold got=%h required=40",
                     {push_msg_val_wrt, push_msg_val_rd, push_msg_data});
        end
`ifdef SPI_MINION_CORE_ABORT_CNT_EN
        total++;
        if (abort_cnt !== a0 + 8'd1) begin
            bad++;
            $display("FAIL short_abort_cnt got=%0d required=%0d", abort_cnt, a0 + 8'd1);
        end
`endif
    endtask

    task automatic test_overrun;
        logic [7:0] mi;
`ifdef SPI_MINION_CORE_ABORT_CNT_EN
        logic [7:0] a0;
        a0 = abort_cnt;
`endif
        spi_xfer(8'h55, 9, mi);
        wait_clk(10);
        check_drained("overrun");
`ifdef SPI_MINION_CORE_ABORT_CNT_EN
        total++;
        if (abort_cnt !== a0 + 8'd1) begin
            bad++;
            $display("FAIL overrun_abort_cnt got=%0d required=%0d", abort_cnt, a0 + 8'd1);
        end
`endif
    endtask

    task automatic test_reset_midpacket;
        int p0;
        logic [7:0] mi;
        spi_cs = 1'b0;
        #100;
        for (int i = 0; i < 4; i++) begin
            spi_mosi = 1'b1;
            #50 spi_sclk = 1'b1;
            #50 spi_sclk = 1'b0;
        end
        spi_mosi = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        wait_clk(3);
        total++;
        if ({spi_miso, pull_en, push_en, push_msg_val_wrt, push_msg_val_rd, push_msg_data} !== 11'd0) begin
            bad++;
            $display("FAIL midreset_outputs got=%b required=0",
                     {spi_miso, pull_en, push_en, push_msg_val_wrt, push_msg_val_rd, push_msg_data});
        end
        p0 = pull_cnt;
        reset = 1'b0;
        wait_clk(12);
        check_pulls("cs_low_after_reset", pull_cnt - p0, 0);
        spi_cs = 1'b1;
        wait_clk(6);
        exp_q.push_back({1'b1, 1'b1, 6'h03});
        spi_xfer(8'hC3, 8, mi);
        wait_clk(10);
        check_drained("after_reset");
        check_pulls("after_reset", pull_cnt - p0, 1);
    endtask

    task automatic test_back_to_back;
        int p0;
        logic [7:0] mi;
        p0 = pull_cnt;
        exp_q.push_back({1'b1, 1'b0, 6'h01});
        exp_q.push_back({1'b0, 1'b1, 6'h3E});
        spi_xfer(8'h81, 8, mi);
        #40;
        spi_xfer(8'h7E, 8, mi);
        wait_clk(10);
        check_drained("back_to_back");
        check_pulls("back_to_back", pull_cnt - p0, 2);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog got=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_write();
        test_read();
        test_short();
        test_overrun();
        test_reset_midpacket();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spi_minion_core.md
SPI_MINION_CORE -- requirements
Module: spi_minion_core

Interface
REQ-001 SHALL have parameter nbits, default 8, meaning SPI packet width in bits (nbits >= 4).
REQ-002 SHALL have port clk  input  1  system clock; the only clock in the block.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port spi_cs  input  1  chip select, active-low, asynchronous to clk.
REQ-005 SHALL have port spi_sclk  input  1  SPI serial clock, mode 0, asynchronous to clk.
REQ-006 SHALL have port spi_mosi  input  1  serial data in, MSB first.
REQ-007 SHALL have port spi_miso  output  1  serial data out, MSB first.
REQ-008 SHALL have port pull_en  output  1  one-cycle request for the outgoing packet.
REQ-009 SHALL have ports pull_msg_val, pull_msg_spc  input  1 each  outgoing packet header bits.
REQ-010 SHALL have port pull_msg_data  input  nbits-2  outgoing payload.
REQ-011 SHALL have port push_en  output  1  one-cycle strobe: received packet valid.
REQ-012 SHALL have ports push_msg_val_wrt, push_msg_val_rd  output  1 each  received header bits.
REQ-013 SHALL have port push_msg_data  output  nbits-2  received payload.

Function
REQ-014 SHALL pass spi_cs, spi_sclk, spi_mosi through two-flop synchronizers plus one history flop each; edges are detected on synchronized values only.
REQ-015 SHALL implement FSM states IDLE, LOAD, SHIFT, DONE.
REQ-016 IDLE -> LOAD on synchronized cs falling edge; LOAD asserts pull_en for exactly one cycle and latches {pull_msg_val, pull_msg_spc, pull_msg_data} into tx_reg in that same cycle; LOAD -> SHIFT unconditionally.
REQ-017 In SHIFT, each synchronized sclk rising edge SHALL shift synchronized mosi into LSB of rx_reg and increment bit_cnt, saturating at nbits+1.
REQ-018 In SHIFT, each synchronized sclk falling edge SHALL shift tx_reg left by one, filling with 0.
REQ-019 spi_miso SHALL equal tx_reg[nbits-1] while synchronized cs is low, else 0.
REQ-020 SHIFT -> DONE on synchronized cs rising edge; DONE lasts one cycle then -> IDLE.
REQ-021 In DONE, if bit_cnt == nbits, push_en SHALL be 1 with push_msg_val_wrt = rx_reg[nbits-1], push_msg_val_rd = rx_reg[nbits-2], push_msg_data = rx_reg[nbits-3:0]; otherwise (short or overrun packet) push_en SHALL stay 0 and the packet is dropped.
REQ-022 push_msg_* SHALL hold their last pushed value until the next push_en.
REQ-023 sclk edges SHALL be ignored in IDLE, LOAD and DONE; a cs falling edge in DONE is honoured on the following IDLE cycle (edge detection uses level history, no lost packet).
REQ-024 clk frequency SHALL be >= 8x spi_sclk frequency; cs high time >= 4 clk cycles.
REQ-025 bit_cnt SHALL clear to 0 on entry to LOAD.

Reset
REQ-026 Asserting reset at any time, including mid-packet, SHALL force state IDLE, synchronizers to idle levels (cs=1, sclk=0, mosi=0), rx_reg, tx_reg, bit_cnt to 0, and pull_en, push_en, spi_miso, push_msg_* to 0.
REQ-027 After reset release with cs already low, no packet SHALL start until cs goes high then low.

Configuration
REQ-028 Macro SPI_MINION_CORE_ABORT_CNT_EN: when defined, SHALL add output abort_cnt (8 bits) counting packets dropped per REQ-021, saturating at 255, cleared by reset; when undefined, port and counter SHALL be absent and function otherwise identical.

Verification (nbits = 8)
REQ-029 Write packet mosi 8'b10_101010, pull inputs val=0,spc=1,data=0 -> one push_en, val_wrt=1, val_rd=0, data=6'h2A; one pull_en at packet start.
REQ-030 Read packet mosi 8'b01_000000, pull inputs val=1,spc=1,data=6'h15 -> miso bit sequence 1,1,0,1,0,1,0,1; push_en with val_rd=1.
REQ-031 cs raised after 5 sclk pulses -> no push_en; abort_cnt 0 -> 1 when macro defined.
REQ-032 9 sclk pulses in one packet -> no push_en (overrun); abort_cnt increments.
REQ-033 reset asserted after 4 bits, released, full 8-bit packet 8'hC3 -> exactly one push_en, data=6'h03, val_wrt=1, val_rd=1.
REQ-034 Two back-to-back packets with 4-cycle cs-high gap -> two pull_en and two push_en pulses, data in order.
